writeback_align: RTL
====================

// Module: writeback_align
// PURPOSE
//  Downstream neighbour of the ALU: re-aligns per-instruction sideband (thread id, rd, write enable,
//  writeback select, PC+4) with the ALU result, which arrives ALU_LATENCY cycles after issue.
//  Selects the final writeback value and drives the register-file write port one cycle later.
//  Sits between the ALU/load return path and the multithreaded register file.
// PARAMETERS
//  DWIDTH       32  datapath width
//  NUM_THREADS  16  hardware threads; TID_WIDTH = $clog2(NUM_THREADS), localparam
//  REGAW        5   register address width
//  ALU_LATENCY  1   ALU issue-to-result cycles, equal to PIPE_STAGE0+PIPE_STAGE1+PIPE_STAGE2; 0..3 legal
//  CNT_WIDTH    32  retire counter width (RETIRE_COUNT_EN only)
// PORTS
//  clk           in   1          clock, rising edge
//  reset         in   1          asynchronous, active-high reset
//  i_valid       in   1          instruction issued to ALU this cycle
//  i_tid         in   TID_WIDTH  thread id at issue
//  i_rd          in   REGAW      destination register at issue
//  i_rf_we       in   1          instruction writes rd
//  i_wb_sel      in   2          wb_sel_e: WB_ALU / WB_LOAD / WB_PC4 / WB_CSR
//  i_pc          in   DWIDTH     PC of the issued instruction
//  i_alu_result  in   DWIDTH     ALU o_result, valid ALU_LATENCY cycles after issue
//  i_load_data   in   DWIDTH     load data, aligned with i_alu_result
//  i_csr_data    in   DWIDTH     CSR read data, aligned with i_alu_result
//  i_cnt_tid     in   TID_WIDTH  retire-counter read select
//  o_valid       out  1          aligned instruction completes this cycle
//  o_rf_we       out  1          register-file write enable
//  o_rf_tid      out  TID_WIDTH  register-file thread select
//  o_rf_addr     out  REGAW      register-file write address
//  o_rf_wdata    out  DWIDTH     register-file write data
//  o_cnt_value   out  CNT_WIDTH  retired count of thread i_cnt_tid
// BEHAVIOUR
//  - Reset, asynchronous: every delay-line valid bit and every output clears to 0; counters clear to 0.
//  - Issue stage computes pc4 = i_pc + 4, modulo 2^DWIDTH, with no carry out. It does not wait for the ALU.
//  - Delay line: {valid, tid, rd, we, wb_sel, pc4} passes through ALU_LATENCY register stages.
//    - ALU_LATENCY=0 makes the delay line a wire.
//    - The delay line never stalls; one new entry is accepted every cycle.
//  - Select, at the aligned cycle: WB_ALU -> i_alu_result; WB_LOAD -> i_load_data; WB_PC4 -> pc4;
//    WB_CSR -> i_csr_data.
//  - Output register, total latency ALU_LATENCY+1 from issue:
//    - o_valid = aligned valid.
//    - o_rf_we = valid & we & (rd != 0). Writes to x0 are suppressed, but o_valid still asserts.
//    - o_rf_tid, o_rf_addr, o_rf_wdata update only when aligned valid = 1; otherwise they hold.
//  - Back-to-back issues, including the same tid on consecutive cycles, emerge in order with no gaps.
//  - Reset asserted mid-flight discards all in-flight entries. No write occurs for them after reset deasserts.
// CONFIGURATION
//  - Macro RETIRE_COUNT_EN defined:
//    - One CNT_WIDTH counter per thread; the counter of o_rf_tid increments on every o_valid cycle,
//      including x0 and no-write instructions.
//    - Counters wrap from 2^CNT_WIDTH-1 to 0.
//    - o_cnt_value is registered: value of counter[i_cnt_tid] one cycle later.
//    - If increment and read hit the same thread in the same cycle, the read returns the pre-increment value.
//  - Macro RETIRE_COUNT_EN undefined: no counter storage exists; o_cnt_value is tied to 0; i_cnt_tid is ignored.
// STRUCTURE
//  - riscv_pkg: typedef enum logic [1:0] wb_sel_e {WB_ALU=0, WB_LOAD=1, WB_PC4=2, WB_CSR=3}.
//  - Sub-module sideband_delay #(WIDTH, DEPTH): generic async-reset shift register, reset on the valid bit only.
//    Instantiated once for the packed sideband.
// TESTING
//  1. ALU_LATENCY=1: issue tid=3, rd=5, WB_ALU; drive i_alu_result=0x0000_00AA in cycle 1
//     -> cycle 2: o_rf_we=1, tid=3, addr=5, wdata=0xAA.
//  2. WB_PC4 with i_pc=0xFFFF_FFFC -> wdata=0x0000_0000, wraps; WB_LOAD with i_load_data=0xDEAD_BEEF -> wdata=0xDEAD_BEEF.
//  3. rd=0, we=1 -> o_valid=1, o_rf_we=0. Also we=0, rd=7 -> o_rf_we=0.
//  4. 16 back-to-back issues, tids 0..15, each wdata=tid+1; rerun with ALU_LATENCY=0, 2 and 3
//     -> 16 consecutive writes, in order, with correct pairing.
//  5. Reset pulse while 2 entries are in flight (ALU_LATENCY=3) -> o_valid and o_rf_we stay 0 thereafter
//     until a new issue arrives.
//  6. RETIRE_COUNT_EN, CNT_WIDTH=4:
//     - 17 retires on tid 2 -> o_cnt_value=1.
//     - Read of tid 2 in the same cycle as a retire -> returns the pre-increment value.
//     - Without the macro -> o_cnt_value is always 0.

Source files
------------

// File: rtl/riscv_pkg.sv
// Writeback-select encoding and sideband sizing shared by the ALU return path.
package riscv_pkg;

  typedef enum logic [1:0] {
    WB_ALU  = 2'd0,
    WB_LOAD = 2'd1,
    WB_PC4  = 2'd2,
    WB_CSR  = 2'd3
  } wb_sel_e;

  localparam int WB_SEL_WIDTH = 2;
  localparam int PC_STEP      = 4;

  // Packed sideband layout: {tid, rd, we, wb_sel, pc4}
  function automatic int sideband_width(input int tid_w, input int regaw, input int dwidth);
    return tid_w + regaw + 1 + WB_SEL_WIDTH + dwidth;
  endfunction

endpackage

// File: rtl/writeback_align_if.sv
// Issue-side and register-file-side signal bundle of writeback_align.
interface writeback_align_if #(
  parameter int DWIDTH      = 32,
  parameter int NUM_THREADS = 16,
  parameter int REGAW       = 5,
  parameter int CNT_WIDTH   = 32
) ();
  import riscv_pkg::*;

  localparam int TID_WIDTH = $clog2(NUM_THREADS);

  logic                 i_valid;
  logic [TID_WIDTH-1:0] i_tid;
  logic [REGAW-1:0]     i_rd;
  logic                 i_rf_we;
  wb_sel_e              i_wb_sel;
  logic [DWIDTH-1:0]    i_pc;
  logic [DWIDTH-1:0]    i_alu_result;
  logic [DWIDTH-1:0]    i_load_data;
  logic [DWIDTH-1:0]    i_csr_data;
  logic [TID_WIDTH-1:0] i_cnt_tid;

  logic                 o_valid;
  logic                 o_rf_we;
  logic [TID_WIDTH-1:0] o_rf_tid;
  logic [REGAW-1:0]     o_rf_addr;
  logic [DWIDTH-1:0]    o_rf_wdata;
  logic [CNT_WIDTH-1:0] o_cnt_value;

  modport master (
    output i_valid, i_tid, i_rd, i_rf_we, i_wb_sel, i_pc,
    output i_alu_result, i_load_data, i_csr_data, i_cnt_tid,
    input  o_valid, o_rf_we, o_rf_tid, o_rf_addr, o_rf_wdata, o_cnt_value
  );

  modport slave (
    input  i_valid, i_tid, i_rd, i_rf_we, i_wb_sel, i_pc,
    input  i_alu_result, i_load_data, i_csr_data, i_cnt_tid,
    output o_valid, o_rf_we, o_rf_tid, o_rf_addr, o_rf_wdata, o_cnt_value
  );

endinterface

// File: rtl/sideband_delay.sv
// Fixed-depth shift register; only the valid bit is reset, payload bits are plain flops.
module sideband_delay #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data
);

  if (DEPTH == 0) begin : g_wire
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ reset;
    assign out_valid      = in_valid;
    assign out_data       = in_data;
  end else begin : g_pipe
    logic [DEPTH-1:0] valid_reg;
    logic [WIDTH-1:0] data_reg [DEPTH];

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        valid_reg <= '0;
      end else begin
        valid_reg[0] <= in_valid;
        for (int i = 1; i < DEPTH; i++) begin
          valid_reg[i] <= valid_reg[i-1];
        end
      end
    end

    always_ff @(posedge clk) begin
      data_reg[0] <= in_data;
      for (int i = 1; i < DEPTH; i++) begin
        data_reg[i] <= data_reg[i-1];
      end
    end

    assign out_valid = valid_reg[DEPTH-1];
    assign out_data  = data_reg[DEPTH-1];
  end

endmodule

// File: rtl/writeback_align.sv
// Re-aligns issue sideband with the ALU result and drives the register-file write port.
// Optional per-thread retire counters are built when RETIRE_COUNT_EN is defined.
module writeback_align
  import riscv_pkg::*;
#(
  parameter int DWIDTH      = 32,
  parameter int NUM_THREADS = 16,
  parameter int REGAW       = 5,
  parameter int ALU_LATENCY = 1,
  parameter int CNT_WIDTH   = 32
) (
  input logic              clk,
  input logic              reset,
  writeback_align_if.slave bus
);

  localparam int TID_WIDTH = $clog2(NUM_THREADS);
  localparam int SB_WIDTH  = sideband_width(TID_WIDTH, REGAW, DWIDTH);

  logic [DWIDTH-1:0]       pc4;
  logic [SB_WIDTH-1:0]     sb_in;
  logic [SB_WIDTH-1:0]     sb_out;
  logic                    al_valid;
  logic [TID_WIDTH-1:0]    al_tid;
  logic [REGAW-1:0]        al_rd;
  logic                    al_we;
  logic [WB_SEL_WIDTH-1:0] al_sel_bits;
  wb_sel_e                 al_sel;
  logic [DWIDTH-1:0]       al_pc4;
  logic [DWIDTH-1:0]       wdata_next;

  logic                    valid_reg;
  logic                    rf_we_reg;
  logic [TID_WIDTH-1:0]    rf_tid_reg;
  logic [REGAW-1:0]        rf_addr_reg;
  logic [DWIDTH-1:0]       rf_wdata_reg;

  // pc4 is formed at issue so only the sum, not the PC, rides the delay line
  assign pc4   = bus.i_pc + DWIDTH'(PC_STEP);
  assign sb_in = {bus.i_tid, bus.i_rd, bus.i_rf_we, bus.i_wb_sel, pc4};

  sideband_delay #(
    .WIDTH (SB_WIDTH),
    .DEPTH (ALU_LATENCY)
  ) u_sideband_delay (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (bus.i_valid),
    .in_data   (sb_in),
    .out_valid (al_valid),
    .out_data  (sb_out)
  );

  assign {al_tid, al_rd, al_we, al_sel_bits, al_pc4} = sb_out;
  assign al_sel = wb_sel_e'(al_sel_bits);

  always_comb begin
    wdata_next = bus.i_alu_result;
    case (al_sel)
      WB_ALU:  wdata_next = bus.i_alu_result;
      WB_LOAD: wdata_next = bus.i_load_data;
      WB_PC4:  wdata_next = al_pc4;
      WB_CSR:  wdata_next = bus.i_csr_data;
      default: wdata_next = bus.i_alu_result;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_reg    <= 1'b0;
      rf_we_reg    <= 1'b0;
      rf_tid_reg   <= '0;
      rf_addr_reg  <= '0;
      rf_wdata_reg <= '0;
    end else begin
      valid_reg <= al_valid;
      rf_we_reg <= al_valid & al_we & (al_rd != '0);
      if (al_valid) begin
        rf_tid_reg   <= al_tid;
        rf_addr_reg  <= al_rd;
        rf_wdata_reg <= wdata_next;
      end
    end
  end

  assign bus.o_valid    = valid_reg;
  assign bus.o_rf_we    = rf_we_reg;
  assign bus.o_rf_tid   = rf_tid_reg;
  assign bus.o_rf_addr  = rf_addr_reg;
  assign bus.o_rf_wdata = rf_wdata_reg;

`ifdef RETIRE_COUNT_EN
  logic [CNT_WIDTH-1:0] cnt_all [NUM_THREADS];
  logic [CNT_WIDTH-1:0] cnt_value_reg;

  for (genvar gi = 0; gi < NUM_THREADS; gi++) begin : g_cnt
    logic [CNT_WIDTH-1:0] cnt_reg;

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        cnt_reg <= '0;
      end else if (valid_reg && (rf_tid_reg == TID_WIDTH'(gi))) begin
        cnt_reg <= cnt_reg + CNT_WIDTH'(1);
      end
    end

    assign cnt_all[gi] = cnt_reg;
  end

  // Sampled at the same edge as any increment, so a colliding read sees the old count
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_value_reg <= '0;
    end else begin
      cnt_value_reg <= cnt_all[bus.i_cnt_tid];
    end
  end

  assign bus.o_cnt_value = cnt_value_reg;
`else
  logic unused_cnt_tid;
  assign unused_cnt_tid  = ^bus.i_cnt_tid;
  assign bus.o_cnt_value = '0;
`endif

endmodule
